// File: rtl/hwag_pkg.sv
// Shared types and constants for the crank/cam wheel signal generators.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TOOTH_HI = 2'd1,
    TOOTH_LO = 2'd2
  } crank_gen_state_t;

  localparam int CRANK_TEETH_TOTAL   = 60;
  localparam int CRANK_TEETH_MISSING = 2;
  localparam int CRANK_PERIOD_MIN    = 4;
  localparam int CRANK_PERIOD_WIDTH  = 24;

endpackage

// File: rtl/crank_pitch_cnt.sv
// Tooth-pitch counter: counts 0..period-1 and flags the half-pitch and terminal positions.
module crank_pitch_cnt
  import hwag_pkg::*;
#(
  parameter int PERIOD_WIDTH = CRANK_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    run_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    half_o,
  output logic                    term_o
);

  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_WIDTH-1:0] half_m1;

  // High phase ends after floor(period/2) cycles; the remainder is the low phase.
  assign half_m1 = (period_i >> 1) - PERIOD_WIDTH'(1);
  assign half_o  = (pcnt_q == half_m1);
  assign term_o  = (pcnt_q == period_i - PERIOD_WIDTH'(1));

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (run_i) begin
      pcnt_d = term_o ? '0 : pcnt_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// Crank wheel emulator: generates a 60-2 style tooth pattern with a programmable pitch.
module crank_wheel_gen
  import hwag_pkg::*;
#(
  parameter int TEETH_TOTAL   = CRANK_TEETH_TOTAL,
  parameter int TEETH_MISSING = CRANK_TEETH_MISSING,
  parameter int PERIOD_WIDTH  = CRANK_PERIOD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  input  logic                    period_wr,
  output logic                    tooth_out,
  output logic [7:0]              tooth_num,
  output logic                    rev_pulse,
  output logic                    busy
);

  localparam logic [7:0]              LAST_TOOTH = 8'(TEETH_TOTAL - 1);
  localparam logic [7:0]              N_PRESENT  = 8'(TEETH_TOTAL - TEETH_MISSING);
  localparam logic [PERIOD_WIDTH-1:0] P_MIN      = PERIOD_WIDTH'(CRANK_PERIOD_MIN);

  crank_gen_state_t        state_q;
  logic [7:0]              tooth_q;
  logic [7:0]              tooth_d;
  logic [PERIOD_WIDTH-1:0] pend_q;
  logic [PERIOD_WIDTH-1:0] act_q;
  logic                    rev_q;
  logic                    out_q;
  logic                    half_hit;
  logic                    term_hit;
  logic                    cnt_clr;

  function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] p);
    return (p < P_MIN) ? P_MIN : p;
  endfunction

  assign cnt_clr = (state_q == IDLE);
  assign tooth_d = (tooth_q == LAST_TOOTH) ? 8'd0 : tooth_q + 8'd1;

  crank_pitch_cnt #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_pitch (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .run_i    (!cnt_clr),
    .period_i (act_q),
    .half_o   (half_hit),
    .term_o   (term_hit)
  );

  // Pending period is only sampled at pitch boundaries, so a write never disturbs the running pitch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tooth_q <= 8'd0;
      pend_q  <= P_MIN;
      act_q   <= P_MIN;
      rev_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      if (period_wr) begin
        pend_q <= clamp_period(period_in);
      end
      rev_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ena) begin
            state_q <= TOOTH_HI;
            tooth_q <= 8'd0;
            act_q   <= pend_q;
            rev_q   <= 1'b1;
            out_q   <= (8'd0 < N_PRESENT);
          end
        end
        TOOTH_HI: begin
          if (half_hit) begin
            state_q <= TOOTH_LO;
            out_q   <= 1'b0;
          end
        end
        TOOTH_LO: begin
          if (term_hit) begin
            if (ena) begin
              state_q <= TOOTH_HI;
              tooth_q <= tooth_d;
              act_q   <= pend_q;
              rev_q   <= (tooth_d == 8'd0);
              out_q   <= (tooth_d < N_PRESENT);
            end else begin
              state_q <= IDLE;
              tooth_q <= 8'd0;
              out_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tooth_out = out_q;
  assign tooth_num = tooth_q;
  assign rev_pulse = rev_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: default 60-2 wheel plus a 36-1 variant.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  logic        rst, ena, period_wr;
  logic [23:0] period_in;
  logic        tooth_out, rev_pulse, busy;
  logic [7:0]  tooth_num;

  logic        rst2, ena2, period_wr2;
  logic [23:0] period_in2;
  logic        tooth_out2, rev_pulse2, busy2;
  logic [7:0]  tooth_num2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crank_wheel_gen dut (
    .clk(clk), .rst(rst), .ena(ena), .period_in(period_in), .period_wr(period_wr),
    .tooth_out(tooth_out), .tooth_num(tooth_num), .rev_pulse(rev_pulse), .busy(busy)
  );

  crank_wheel_gen #(.TEETH_TOTAL(36), .TEETH_MISSING(1), .PERIOD_WIDTH(24)) dut36 (
    .clk(clk), .rst(rst2), .ena(ena2), .period_in(period_in2), .period_wr(period_wr2),
    .tooth_out(tooth_out2), .tooth_num(tooth_num2), .rev_pulse(rev_pulse2), .busy(busy2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Measure one pitch of dut starting at its first cycle; optionally write a period at cycle wr_at.
  task automatic meas(input int wr_at, input int val, output int hi, output int tot);
    logic [7:0] t0;
    t0  = tooth_num;
    hi  = 0;
    tot = 0;
    while (tooth_num == t0 && busy && tot < 1000) begin
      if (tot == wr_at) begin
        period_in = 24'(val);
        period_wr = 1'b1;
      end else begin
        period_wr = 1'b0;
      end
      hi += int'(tooth_out);
      tot++;
      tick();
    end
    period_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi, tot, rises, revs, late_hi, maxn, n;
    logic prev;

    rst = 1'b0; ena = 1'b0; period_wr = 1'b0; period_in = '0;
    rst2 = 1'b0; ena2 = 1'b0; period_wr2 = 1'b0; period_in2 = '0;
    tick(); tick();
    chk("rst_out", tooth_out, 0);
    chk("rst_num", tooth_num, 0);
    chk("rst_rev", rev_pulse, 0);
    chk("rst_busy", busy, 0);

    // Default pending period after reset is 4
    rst = 1'b1; ena = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_rev", rev_pulse, 1);
    chk("start_out", tooth_out, 1);
    meas(-1, 0, hi, tot);
    chk("dflt_hi", hi, 2);
    chk("dflt_tot", tot, 4);

    // Steady run at period 8
    rst = 1'b0; ena = 1'b0;
    tick();
    rst = 1'b1; period_in = 24'd8; period_wr = 1'b1;
    tick();
    period_wr = 1'b0; ena = 1'b1;
    tick();
    chk("run_num0", tooth_num, 0);
    rises = 0; revs = 0; late_hi = 0; maxn = 0; hi = 0; prev = 1'b0;
    for (int i = 0; i < 480; i++) begin
      if (tooth_out && !prev) rises++;
      hi += int'(tooth_out);
      revs += int'(rev_pulse);
      if (i >= 464) late_hi += int'(tooth_out);
      if (int'(tooth_num) > maxn) maxn = int'(tooth_num);
      prev = tooth_out;
      tick();
    end
    chk("run_pulses", rises, 58);
    chk("run_hi_clks", hi, 232);
    chk("run_gap_hi", late_hi, 0);
    chk("run_revs", revs, 1);
    chk("run_maxnum", maxn, 59);
    chk("run_rev480", rev_pulse, 1);
    chk("run_num480", tooth_num, 0);
    meas(-1, 0, hi, tot);
    chk("run_t0_hi", hi, 4);
    chk("run_t0_tot", tot, 8);

    // Mid-pitch write of 12 at pcnt=3 (tooth 1)
    meas(3, 12, hi, tot);
    chk("mid_cur_tot", tot, 8);
    chk("mid_cur_hi", hi, 4);
    meas(-1, 0, hi, tot);
    chk("mid_nxt_tot", tot, 12);
    chk("mid_nxt_hi", hi, 6);

    // Write coinciding with the boundary (tooth 3): old pending loads first
    meas(11, 8, hi, tot);
    chk("bnd_cur_tot", tot, 12);
    meas(-1, 0, hi, tot);
    chk("bnd_old_tot", tot, 12);
    meas(-1, 0, hi, tot);
    chk("bnd_new_tot", tot, 8);

    // Clamp 2 -> 4, then odd period 9
    meas(0, 2, hi, tot);
    chk("clamp_cur_tot", tot, 8);
    meas(-1, 0, hi, tot);
    chk("clamp_hi", hi, 2);
    chk("clamp_tot", tot, 4);
    meas(0, 9, hi, tot);
    chk("odd_cur_tot", tot, 4);
    meas(-1, 0, hi, tot);
    chk("odd_hi", hi, 4);
    chk("odd_tot", tot, 9);

    // Stop at tooth 10, pcnt 2
    chk("stop_num", tooth_num, 10);
    tick(); tick();
    ena = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("stop_cycles", n, 7);
    chk("stop_busy", busy, 0);
    chk("stop_out", tooth_out, 0);
    tick(); tick();
    chk("idle_busy", busy, 0);
    ena = 1'b1;
    tick();
    chk("restart_num", tooth_num, 0);
    chk("restart_rev", rev_pulse, 1);
    chk("restart_out", tooth_out, 1);
    meas(-1, 0, hi, tot);
    chk("restart_tot", tot, 9);

    // Brief ena drop inside a pitch does not interrupt
    ena = 1'b0;
    tick();
    ena = 1'b1;
    n = 0;
    while (tooth_num == 8'd1 && n < 100) begin
      tick();
      n++;
    end
    chk("blip_cycles", n, 8);
    chk("blip_num", tooth_num, 2);
    chk("blip_busy", busy, 1);

    // Reset in TOOTH_HI of tooth 30, with a concurrent period write
    n = 0;
    while (tooth_num != 8'd30 && n < 2000) begin
      tick();
      n++;
    end
    chk("t30_num", tooth_num, 30);
    chk("t30_out", tooth_out, 1);
    rst = 1'b0; period_in = 24'd20; period_wr = 1'b1;
    tick();
    chk("mrst_out", tooth_out, 0);
    chk("mrst_num", tooth_num, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rev", rev_pulse, 0);
    rst = 1'b1; period_wr = 1'b0;
    tick();
    chk("mrst_restart_rev", rev_pulse, 1);
    meas(-1, 0, hi, tot);
    chk("mrst_hi", hi, 2);
    chk("mrst_tot", tot, 4);
    ena = 1'b0;

    // 36-1 wheel at period 10
    rst2 = 1'b1; period_in2 = 24'd10; period_wr2 = 1'b1;
    tick();
    period_wr2 = 1'b0; ena2 = 1'b1;
    tick();
    chk("w36_rev0", rev_pulse2, 1);
    rises = 0; revs = 0; late_hi = 0; maxn = 0; hi = 0; prev = 1'b0;
    for (int i = 0; i < 360; i++) begin
      if (tooth_out2 && !prev) rises++;
      hi += int'(tooth_out2);
      revs += int'(rev_pulse2);
      if (i >= 350) late_hi += int'(tooth_out2);
      if (int'(tooth_num2) > maxn) maxn = int'(tooth_num2);
      prev = tooth_out2;
      tick();
    end
    chk("w36_pulses", rises, 35);
    chk("w36_hi_clks", hi, 175);
    chk("w36_gap_hi", late_hi, 0);
    chk("w36_revs", revs, 1);
    chk("w36_maxnum", maxn, 35);
    chk("w36_rev360", rev_pulse2, 1);
    chk("w36_num360", tooth_num2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crank_wheel_gen.md
CRANK_WHEEL_GEN -- requirements
Module: crank_wheel_gen

Interface
REQ-001 The block SHALL have parameter TEETH_TOTAL, default 60, meaning tooth positions per revolution including missing teeth.
REQ-002 The block SHALL have parameter TEETH_MISSING, default 2, meaning the number of missing teeth, placed at the last positions of the revolution.
REQ-003 The block SHALL have parameter PERIOD_WIDTH, default 24, meaning the width of the tooth-pitch period in clocks.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous active-low reset.
REQ-007 Port ena, input, 1: run request; high starts or keeps generation running.
REQ-008 Port period_in, input, PERIOD_WIDTH: requested tooth pitch in clocks.
REQ-009 Port period_wr, input, 1: one-cycle strobe that captures period_in into the pending register.
REQ-010 Port tooth_out, output, 1: emulated sensor signal, high during the first half of each present tooth pitch.
REQ-011 Port tooth_num, output, 8: current tooth position, 0..TEETH_TOTAL-1.
REQ-012 Port rev_pulse, output, 1: one-cycle pulse in the first cycle of tooth 0.
REQ-013 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, TOOTH_HI and TOOTH_LO.
REQ-015 In IDLE with ena=1, the next state SHALL be TOOTH_HI, with pitch counter pcnt=0, tooth_num=0, active period loaded from pending, and rev_pulse asserted in that first cycle.
REQ-016 pcnt SHALL count 0..period_act-1.
REQ-017 The FSM SHALL move TOOTH_HI->TOOTH_LO when pcnt reaches (period_act>>1)-1.
REQ-018 At pcnt=period_act-1 the block SHALL reset pcnt to 0, advance tooth_num, and load period_act from pending.
REQ-019 tooth_num SHALL wrap TEETH_TOTAL-1 -> 0, and rev_pulse SHALL pulse on that wrap.
REQ-020 tooth_out SHALL be high iff state=TOOTH_HI and tooth_num < TEETH_TOTAL-TEETH_MISSING; missing positions stay low for their full pitch.
REQ-021 tooth_out SHALL be decoded from registered state only, with no combinational path from any input.
REQ-022 period_wr SHALL update only the pending register; a change never alters a pitch in progress.
REQ-023 A pending or active value below 4 SHALL be clamped to 4; an odd period gives a high time of floor(period/2) and a low time equal to the remainder.
REQ-024 With ena=0 while running, the block SHALL finish the current pitch, enter IDLE at the boundary, and drive tooth_out low.
REQ-025 If ena returns to 1 before that boundary, the block SHALL continue without interruption.
REQ-026 Restart from IDLE SHALL always begin at tooth 0.
REQ-027 If period_wr coincides with a pitch boundary, the boundary SHALL load the old pending value, and the new value applies from the following boundary.

Reset
REQ-028 With rst=0 at a clock edge, the block SHALL enter IDLE with pcnt=0, tooth_num=0, tooth_out=0, rev_pulse=0 and busy=0.
REQ-029 Reset SHALL set pending and active period to 4.
REQ-030 Reset mid-pitch SHALL abort immediately, with no completion of the current tooth.
REQ-031 rst SHALL override ena and period_wr.

Structure
REQ-032 Shared package hwag_pkg SHALL hold the state typedef crank_gen_state_t, CRANK_TEETH_TOTAL=60, CRANK_TEETH_MISSING=2, CRANK_PERIOD_MIN=4 and the PERIOD_WIDTH default.
REQ-033 The pitch counter with terminal and half-period compare SHALL be a sub-module, crank_pitch_cnt; everything else lives in crank_wheel_gen.

Verification
REQ-034 Steady run: period_wr with 8, then ena=1 -> per revolution 58 pulses of 4 clocks high / 4 clocks low, then 16 low clocks; rev_pulse every 480 clocks; tooth_num runs 0..59.
REQ-035 Mid-pitch update: period 8 running, period_wr=12 at pcnt=3 -> current pitch stays 8 clocks, next pitch is 12 clocks (6 high).
REQ-036 Clamp/odd period: period_wr=2 -> pitch 4 (2 high / 2 low); period_wr=9 -> 4 high / 5 low.
REQ-037 Stop/restart: ena=0 at tooth 10, pcnt=2 -> pitch completes, IDLE, busy=0; ena=1 again -> tooth_num=0 with rev_pulse.
REQ-038 Reset mid-operation: rst=0 for 1 cycle at tooth 30 in TOOTH_HI -> next cycle tooth_out=0, tooth_num=0, busy=0, period_act=4.
REQ-039 Parameter variant: TEETH_TOTAL=36, TEETH_MISSING=1, period 10 -> 35 pulses then 10 low clocks, revolution length 360 clocks.
